vga_timing_gen: RTL
===================

# vga_timing_gen

Generates the VGA 640x480@60 Hz raster timing for the display path: derives a pixel-rate enable from the 100 MHz system clock and runs the horizontal and vertical counters. It also produces hsync, vsync, the active-video flag and frame/line start pulses. It sits directly upstream of the scene renderers (title, game, win scenes), which consume `h_cnt`/`v_cnt` to compute `pixel_addr` and `vga_data`, and it drives the board's sync pins.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; must be ≥1.
- `H_ACTIVE`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal segments; `H_TOTAL` = sum = 800.
- `V_ACTIVE`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical segments; `V_TOTAL` = sum = 525.
- `SYNC_DELAY`, 2: pixel ticks of sync/valid delay; only used with the macro.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pclk_en`  out  1  one-`clk` pixel tick.
- `h_cnt`  out  10  horizontal pixel counter.
- `v_cnt`  out  10  vertical line counter.
- `valid`  out  1  high when the current pixel is in the active area.
- `hsync`  out  1  horizontal sync, active-low.
- `vsync`  out  1  vertical sync, active-low.
- `frame_start`  out  1  one-`clk` pulse when the counters reach (0,0).
- `line_start`  out  1  one-`clk` pulse when `h_cnt` reaches 0.

## Operation
- Divider `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `pclk_en` is a registered flag, high when `div_cnt` == `CLK_DIV`-1. With `CLK_DIV`=1, `pclk_en` is constantly high after reset.
- Counters advance only on edges where `pclk_en` is high:
  - `h_cnt` increments; at `H_TOTAL`-1 it wraps to 0 and `v_cnt` advances.
  - `v_cnt` increments; at `V_TOTAL`-1 (when `h_cnt` also wraps) it wraps to 0.
- Outputs are registered on the same edge from the next counter values; nothing is combinationally decoded after the flops:
  - `valid` = h < `H_ACTIVE` and v < `V_ACTIVE`.
  - `hsync` = 0 iff h is in [656,752).
  - `vsync` = 0 iff v is in [490,492).
  - In general the sync windows are [ACTIVE+FP, ACTIVE+FP+SYNC).
- `line_start` = 1 for one `clk` after the edge where h wraps to 0. `frame_start` = 1 for one `clk` after the edge where both counters wrap to 0.
- Reset values (asynchronous, applied while `rst_n`=0):
  - `div_cnt`=0, `pclk_en`=0.
  - `h_cnt`=799 (`H_TOTAL`-1), `v_cnt`=524 (`V_TOTAL`-1).
  - `valid`=0, `hsync`=1, `vsync`=1, `frame_start`=0, `line_start`=0.
  - The first pixel tick after release therefore rolls the counters to (0,0) and fires both pulses; no pixel of the first frame is skipped.
- Reset mid-frame: all outputs return to their reset values immediately. After release a fresh frame starts; no partial-frame state is retained.

## Timing
- Cycle 0 is the first rising edge with `rst_n`=1. `pclk_en` is high in cycles `CLK_DIV`-1, 2·`CLK_DIV`-1, and so on.
- Each counter value is held for exactly `CLK_DIV` clocks.
- `valid`, `hsync` and `vsync` are cycle-aligned with the counter value they describe (zero latency relative to `h_cnt`/`v_cnt`) unless the macro is enabled.
- `line_start` and `frame_start` are high in the first `clk` cycle of the new `h_cnt`=0 value only.
- Line period: `H_TOTAL`·`CLK_DIV` = 3200 clk. Frame period: 1 680 000 clk.

## Configuration
- `VGA_SYNC_DELAY_EN` defined:
  - `valid`, `hsync` and `vsync` each pass through a `SYNC_DELAY`-stage shift register that advances only on `pclk_en`. This matches scene decode plus block-RAM read latency.
  - All stages reset to valid=0, hsync=1, vsync=1.
  - `h_cnt`, `v_cnt`, `pclk_en`, `line_start` and `frame_start` stay undelayed.
- Not defined: no delay stages; outputs are aligned with the counters as above.

## Test plan
- Reset release, default params → `pclk_en` first high at cycle 3. Cycle 4: `h_cnt`=0, `v_cnt`=0, `valid`=1, `frame_start`=1 and `line_start`=1, for one clk only.
- Line sweep → `valid` drops when `h_cnt`=640. `hsync`=0 for `h_cnt` 656..751 (384 clk). After h=799, `h_cnt`=0, `v_cnt` increments and `line_start` pulses.
- Frame sweep → `valid`=0 from `v_cnt`=480. `vsync`=0 only on lines 490 and 491. From (799,524) the counters go to (0,0) with `frame_start`. The interval between `frame_start` pulses is 1 680 000 clk.
- Assert `rst_n`=0 asynchronously at h=300, v=200 → same-cycle outputs: `h_cnt`=799, `v_cnt`=524, `valid`=0, `hsync`=1, `vsync`=1, pulses 0. After release the Test 1 sequence repeats.
- `CLK_DIV`=1 → `pclk_en` constantly high; `h_cnt` increments every clk; line period 800 clk.
- `VGA_SYNC_DELAY_EN` with `SYNC_DELAY`=2 → `valid` rises 8 clk after `h_cnt` becomes 0 on an active line. `hsync` falls while `h_cnt`=658.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing (pixel enable, h/v counters, syncs, pulses).
// Optional VGA_SYNC_DELAY_EN: delays valid/hsync/vsync by SYNC_DELAY pixel ticks. Rev 1.0
`default_nettype none

module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pclk_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_nxt;
  logic [9:0]       v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             valid_nxt;
  logic             hsync_nxt;
  logic             vsync_nxt;
  logic             valid_al;
  logic             hsync_al;
  logic             vsync_al;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pclk_en <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      pclk_en <= (div_cnt == DIV_LAST);
    end
  end

  // Decode from the next counter values so the flags land aligned with the counters.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    if (pclk_en) begin
      if (h_wrap) begin
        h_nxt = '0;
        v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
    valid_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hsync_nxt = !((h_nxt >= HS_START) && (h_nxt < HS_END));
    vsync_nxt = !((v_nxt >= VS_START) && (v_nxt < VS_END));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      valid_al    <= 1'b0;
      hsync_al    <= 1'b1;
      vsync_al    <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      valid_al    <= valid_nxt;
      hsync_al    <= hsync_nxt;
      vsync_al    <= vsync_nxt;
      line_start  <= pclk_en && h_wrap;
      frame_start <= pclk_en && h_wrap && v_wrap;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] valid_sr;
  logic [SYNC_DELAY-1:0] hsync_sr;
  logic [SYNC_DELAY-1:0] vsync_sr;

  // Pixel-rate delay line covering scene decode and block-RAM read latency.
  for (genvar i = 0; i < SYNC_DELAY; i++) begin : g_delay
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_sr[i] <= 1'b0;
        hsync_sr[i] <= 1'b1;
        vsync_sr[i] <= 1'b1;
      end else if (pclk_en) begin
        if (i == 0) begin
          valid_sr[i] <= valid_al;
          hsync_sr[i] <= hsync_al;
          vsync_sr[i] <= vsync_al;
        end else begin
          valid_sr[i] <= valid_sr[(i > 0) ? i - 1 : 0];
          hsync_sr[i] <= hsync_sr[(i > 0) ? i - 1 : 0];
          vsync_sr[i] <= vsync_sr[(i > 0) ? i - 1 : 0];
        end
      end
    end
  end

  assign valid = valid_sr[SYNC_DELAY-1];
  assign hsync = hsync_sr[SYNC_DELAY-1];
  assign vsync = vsync_sr[SYNC_DELAY-1];
`else
  assign valid = valid_al;
  assign hsync = hsync_al;
  assign vsync = vsync_al;
`endif

endmodule

`default_nettype wire
